load_store_unit: RTL and testbench

Byte-addressed load/store front end between the RISC-V core's execute stage and the data cache (`CacheData`). It accepts one RV32I memory operation at a time, encoded as the instruction's funct3. It translates the operation into a word-aligned cache access with byte write enables and lane-shifted store data. It then runs the cache's enable/valid/busy handshake, and returns sign- or zero-extended load data to the core with a completion pulse. Misaligned or illegal operations are rejected without touching the cache.

---
 rtl/load_store_unit.sv | 169 ++++++++++++++++
 tb/tb_load_store_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store front end: turns one byte-addressed memory op into a
// word-aligned cache access and returns the extended load result.
module load_store_unit #(
  parameter int ADDRESS_BITWIDTH = 32,
  parameter int DATA_BITWIDTH    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req,
  input  logic                        is_store,
  input  logic [2:0]                  funct3,
  input  logic [ADDRESS_BITWIDTH-1:0] addr,
  input  logic [DATA_BITWIDTH-1:0]    store_data,
  output logic                        busy,
  output logic                        done,
  output logic                        fault,
  output logic [DATA_BITWIDTH-1:0]    load_data,
  output logic                        enable,
  output logic [ADDRESS_BITWIDTH-1:0] address,
  output logic [DATA_BITWIDTH-1:0]    data_in,
  output logic [3:0]                  write_enable_bytes,
  input  logic [DATA_BITWIDTH-1:0]    data_out,
  input  logic                        data_out_valid,
  input  logic                        cache_busy
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DATA,
    WAIT_CACHE,
    FAULT
  } state_t;

  state_t state, state_next;

  logic                        op_store;
  logic [2:0]                  op_f3;
  logic [ADDRESS_BITWIDTH-1:0] op_addr;
  logic [DATA_BITWIDTH-1:0]    op_data;
  logic [1:0]                  op_off;
  logic                        req_ok;
  logic [DATA_BITWIDTH-1:0]    store_shift;
  logic [3:0]                  store_strb;
  logic [DATA_BITWIDTH-1:0]    load_word;
  logic [DATA_BITWIDTH-1:0]    load_ext;

  assign op_off = op_addr[1:0];

  // Legality and alignment are judged on the raw request, before latching.
  always_comb begin
    req_ok = 1'b0;
    case (funct3)
      F3_B:    req_ok = 1'b1;
      F3_H:    req_ok = ~addr[0];
      F3_W:    req_ok = (addr[1:0] == 2'b00);
      F3_BU:   req_ok = ~is_store;
      F3_HU:   req_ok = ~is_store & ~addr[0];
      default: req_ok = 1'b0;
    endcase
  end

  always_comb begin
    store_shift = op_data << {op_off, 3'b000};
    case (op_f3[1:0])
      2'b00:   store_strb = 4'b0001 << op_off;
      2'b01:   store_strb = 4'b0011 << op_off;
      default: store_strb = 4'b1111;
    endcase
  end

  always_comb begin
    load_word = data_out >> {op_off, 3'b000};
    case (op_f3)
      F3_B:    load_ext = {{(DATA_BITWIDTH-8){load_word[7]}}, load_word[7:0]};
      F3_BU:   load_ext = {{(DATA_BITWIDTH-8){1'b0}}, load_word[7:0]};
      F3_H:    load_ext = {{(DATA_BITWIDTH-16){load_word[15]}}, load_word[15:0]};
      F3_HU:   load_ext = {{(DATA_BITWIDTH-16){1'b0}}, load_word[15:0]};
      default: load_ext = load_word;
    endcase
  end

  // Cache-side outputs are only non-zero during the single enable cycle.
  always_comb begin
    state_next         = state;
    enable             = 1'b0;
    address            = '0;
    data_in            = '0;
    write_enable_bytes = '0;
    case (state)
      IDLE: begin
        if (req) state_next = req_ok ? ISSUE : FAULT;
      end
      ISSUE: begin
        if (!cache_busy) begin
          enable             = 1'b1;
          address            = {op_addr[ADDRESS_BITWIDTH-1:2], 2'b00};
          data_in            = store_shift;
          write_enable_bytes = op_store ? store_strb : 4'b0000;
          state_next         = op_store ? WAIT_CACHE : WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (data_out_valid) state_next = cache_busy ? WAIT_CACHE : IDLE;
      end
      WAIT_CACHE: begin
        if (!cache_busy) state_next = IDLE;
      end
      FAULT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      load_data <= '0;
      op_store  <= 1'b0;
      op_f3     <= '0;
      op_addr   <= '0;
      op_data   <= '0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            op_store <= is_store;
            op_f3    <= funct3;
            op_addr  <= addr;
            op_data  <= store_data;
            busy     <= 1'b1;
            if (!req_ok) begin
              done  <= 1'b1;
              fault <= 1'b1;
            end
          end
        end
        FAULT: busy <= 1'b0;
        WAIT_DATA: begin
          if (data_out_valid) begin
            load_data <= load_ext;
            done      <= 1'b1;
            if (!cache_busy) busy <= 1'b0;
          end
        end
        WAIT_CACHE: begin
          // Loads already signalled done; only stores complete here.
          if (!cache_busy) begin
            busy <= 1'b0;
            if (op_store) done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a small two-word cache model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        busy, done, fault, enable;
  logic [31:0] load_data, address, data_in;
  logic [3:0]  write_enable_bytes;
  logic [31:0] data_out = 32'h0;
  logic        data_out_valid = 1'b0;
  logic        cache_busy = 1'b0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDRESS_BITWIDTH(32), .DATA_BITWIDTH(32)) dut (
    .clk(clk), .rst(rst), .req(req), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .busy(busy), .done(done),
    .fault(fault), .load_data(load_data), .enable(enable), .address(address),
    .data_in(data_in), .write_enable_bytes(write_enable_bytes),
    .data_out(data_out), .data_out_valid(data_out_valid), .cache_busy(cache_busy)
  );

  // Cache model: valid lat_p cycles after enable; busy from the cycle after
  // enable until hold_p cycles after valid (loads) or shold_p cycles (stores).
  int          cyc = 0;
  int          v_at = -1;
  int          b_until = -1;
  int          lat_p = 1;
  int          hold_p = 0;
  int          shold_p = 0;
  logic        rd_idx = 1'b0;
  logic [31:0] mem [2] = '{32'hB7C6A980, 32'h3F5A2E14};

  always @(posedge clk) begin
    int n;
    n = cyc + 1;
    if (rst) begin
      v_at = -1;
      b_until = -1;
    end else if (enable) begin
      rd_idx = address[2];
      if (write_enable_bytes != 4'b0000) begin
        for (int i = 0; i < 4; i++)
          if (write_enable_bytes[i]) mem[address[2]][8*i +: 8] = data_in[8*i +: 8];
        v_at = -1;
        b_until = cyc + shold_p;
      end else begin
        v_at = cyc + lat_p;
        b_until = cyc + lat_p + hold_p - 1;
      end
    end
    cyc = n;
    data_out_valid <= (n == v_at);
    data_out       <= (n == v_at) ? mem[rd_idx] : 32'h0;
    cache_busy     <= (n <= b_until);
  end

  typedef struct { logic flt; logic chk; logic [31:0] data; int at; } done_t;
  typedef struct { logic [31:0] adr; logic [3:0] web; logic [31:0] din; int at; } en_t;
  done_t dq[$];
  en_t   eq[$];
  int    rq[$];
  int    tests = 0;
  int    failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic prev_busy = 1'b0;
  logic prev_en = 1'b0;

  always @(negedge clk) begin
    done_t d;
    en_t   e;
    if (rst) begin
      prev_busy = 1'b0;
      prev_en = 1'b0;
    end else begin
      if (done) begin
        if (dq.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else begin
          d = dq.pop_front();
          check("done_cycle", cyc, d.at);
          check("fault", {31'b0, fault}, {31'b0, d.flt});
          if (d.chk) check("load_data", load_data, d.data);
        end
      end
      if (enable) begin
        check("enable_while_cache_busy", {31'b0, cache_busy}, 32'd0);
        check("enable_repeat", {31'b0, prev_en}, 32'd0);
        if (eq.size() == 0) check("unexpected_enable", 32'd1, 32'd0);
        else begin
          e = eq.pop_front();
          check("enable_cycle", cyc, e.at);
          check("address", address, e.adr);
          check("write_enable_bytes", {28'b0, write_enable_bytes}, {28'b0, e.web});
          check("data_in", data_in, e.din);
        end
      end
      if (prev_busy && !busy) begin
        if (rq.size() == 0) check("unexpected_release", 32'd1, 32'd0);
        else check("release_cycle", cyc, rq.pop_front());
      end
      prev_busy = busy;
      prev_en = enable;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 200) begin
      step();
      k++;
    end
    if (busy) check("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input int lat, input int hold, input int shold,
                       input logic exp_fault, input logic [31:0] exp_data,
                       input logic [3:0] exp_web, input logic [31:0] exp_din);
    int t;
    wait_idle();
    lat_p = lat;
    hold_p = hold;
    shold_p = shold;
    t = cyc;
    req = 1'b1;
    is_store = st;
    funct3 = f3;
    addr = a;
    store_data = sd;
    if (exp_fault) begin
      dq.push_back(done_t'{1'b1, 1'b0, 32'h0, t + 1});
      rq.push_back(t + 2);
    end else begin
      eq.push_back(en_t'{a & 32'hFFFF_FFFC, exp_web, exp_din, t + 1});
      if (st) begin
        dq.push_back(done_t'{1'b0, 1'b0, 32'h0, t + 3 + shold});
        rq.push_back(t + 3 + shold);
      end else begin
        dq.push_back(done_t'{1'b0, 1'b1, exp_data, t + 2 + lat});
        rq.push_back(t + 2 + lat + hold);
      end
    end
    step();
    check("busy_after_accept", {31'b0, busy}, 32'd1);
    req = 1'b0;
    is_store = 1'b0;
    funct3 = 3'b000;
    addr = 32'h0;
    store_data = 32'h0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_fault"}, {31'b0, fault}, 32'd0);
    check({tag, "_enable"}, {31'b0, enable}, 32'd0);
    check({tag, "_load_data"}, load_data, 32'h0);
    check({tag, "_address"}, address, 32'h0);
    check({tag, "_data_in"}, data_in, 32'h0);
    check({tag, "_web"}, {28'b0, write_enable_bytes}, 32'd0);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;

    // Loads from the initial image
    issue(1'b0, 3'b000, 32'h1, 32'h0, 2, 0, 0, 1'b0, 32'hFFFFFFA9, 4'b0000, 32'h0);
    issue(1'b0, 3'b100, 32'h1, 32'h0, 1, 0, 0, 1'b0, 32'h000000A9, 4'b0000, 32'h0);
    issue(1'b0, 3'b001, 32'h2, 32'h0, 3, 2, 0, 1'b0, 32'hFFFFB7C6, 4'b0000, 32'h0);
    issue(1'b0, 3'b101, 32'h6, 32'h0, 2, 1, 0, 1'b0, 32'h00003F5A, 4'b0000, 32'h0);
    issue(1'b0, 3'b010, 32'h4, 32'h0, 1, 3, 0, 1'b0, 32'h3F5A2E14, 4'b0000, 32'h0);

    // Stores followed by readback
    issue(1'b1, 3'b000, 32'h1, 32'h12345678, 1, 0, 2, 1'b0, 32'h0, 4'b0010, 32'h34567800);
    issue(1'b0, 3'b010, 32'h0, 32'h0, 1, 0, 0, 1'b0, 32'hB7C67880, 4'b0000, 32'h0);
    issue(1'b1, 3'b000, 32'h1, 32'h000000A9, 1, 0, 0, 1'b0, 32'h0, 4'b0010, 32'h0000A900);
    issue(1'b1, 3'b001, 32'h2, 32'h0000BEEF, 1, 0, 1, 1'b0, 32'h0, 4'b1100, 32'hBEEF0000);
    issue(1'b0, 3'b010, 32'h0, 32'h0, 1, 0, 0, 1'b0, 32'hBEEFA980, 4'b0000, 32'h0);
    issue(1'b1, 3'b010, 32'h4, 32'hCAFEF00D, 1, 0, 0, 1'b0, 32'h0, 4'b1111, 32'hCAFEF00D);
    issue(1'b0, 3'b000, 32'h7, 32'h0, 1, 0, 0, 1'b0, 32'hFFFFFFCA, 4'b0000, 32'h0);
    issue(1'b0, 3'b101, 32'h4, 32'h0, 2, 0, 0, 1'b0, 32'h0000F00D, 4'b0000, 32'h0);

    // Misaligned and illegal requests
    issue(1'b0, 3'b010, 32'h2, 32'h0, 1, 0, 0, 1'b1, 32'h0, 4'b0000, 32'h0);
    issue(1'b0, 3'b001, 32'h3, 32'h0, 1, 0, 0, 1'b1, 32'h0, 4'b0000, 32'h0);
    issue(1'b1, 3'b100, 32'h0, 32'h0, 1, 0, 0, 1'b1, 32'h0, 4'b0000, 32'h0);
    issue(1'b0, 3'b011, 32'h0, 32'h0, 1, 0, 0, 1'b1, 32'h0, 4'b0000, 32'h0);
    issue(1'b0, 3'b101, 32'h1, 32'h0, 1, 0, 0, 1'b1, 32'h0, 4'b0000, 32'h0);
    issue(1'b1, 3'b010, 32'h1, 32'h0, 1, 0, 0, 1'b1, 32'h0, 4'b0000, 32'h0);
    issue(1'b1, 3'b001, 32'h3, 32'h0, 1, 0, 0, 1'b1, 32'h0, 4'b0000, 32'h0);

    // Dirty evict: done at valid+1, busy held, stray req ignored
    issue(1'b0, 3'b010, 32'h0, 32'h0, 2, 5, 0, 1'b0, 32'hBEEFA980, 4'b0000, 32'h0);
    repeat (4) step();
    check("busy_in_evict", {31'b0, busy}, 32'd1);
    req = 1'b1;
    funct3 = 3'b000;
    addr = 32'h0;
    repeat (3) step();
    req = 1'b0;

    // Reset while waiting for load data
    issue(1'b0, 3'b010, 32'h4, 32'h0, 6, 5, 0, 1'b0, 32'hCAFEF00D, 4'b0000, 32'h0);
    step();
    step();
    check("busy_before_reset", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    dq.delete();
    eq.delete();
    rq.delete();
    step();
    check_all_zero("midreset");
    rst = 1'b0;
    repeat (8) step();

    issue(1'b0, 3'b010, 32'h4, 32'h0, 1, 0, 0, 1'b0, 32'hCAFEF00D, 4'b0000, 32'h0);

    k = 0;
    while ((dq.size() + eq.size() + rq.size()) != 0 && k < 300) begin
      step();
      k++;
    end
    check("drain", dq.size() + eq.size() + rq.size(), 32'd0);
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
